string_format: RTL and testbench

- Inverse of the ASCII-to-binary preprocess stage: formats `in_strlen` binary byte values as a space-separated ASCII decimal string.
- Output is packed in the same layout the preprocess stage consumes.
- Sits on the result/readback path: the controller hands it a value vector and collects the string.
- Output is held, with the same `string_en`/`signal_from_controller` handshake, until the controller acknowledges it.

---
 rtl/string_format_pkg.sv | 17 +
 rtl/string_format_bin2bcd.sv | 27 ++
 rtl/string_format.sv | 151 +++++++++++++++
 tb/tb_string_format.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/string_format_pkg.sv
// Shared definitions for the ASCII string preprocess/format pair so both sides stay sized together.
package string_format_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam int DEF_DWIDTH     = 8;
  localparam int DEF_IN_STRLEN  = 10;
  localparam int DEF_OUT_STRLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/string_format_bin2bcd.sv
// Combinational double-dabble: 8-bit binary to three BCD digits plus count of significant digits (1..3).
module string_format_bin2bcd (
  input  logic [7:0] bin_i,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic [1:0] ndig_o
);

  logic [19:0] sh;

  always_comb begin
    sh = {12'd0, bin_i};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
  end

  assign hund_o = sh[19:16];
  assign tens_o = sh[15:12];
  assign ones_o = sh[11:8];
  assign ndig_o = (hund_o != 4'd0) ? 2'd3 : ((tens_o != 4'd0) ? 2'd2 : 2'd1);

endmodule

// File: rtl/string_format.sv
// Formats a vector of byte values as a space-separated decimal ASCII string, one character per clock,
// then presents it with a valid/acknowledge handshake and a truncation flag.
module string_format
  import string_format_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int in_strlen  = DEF_IN_STRLEN,
  parameter int out_strlen = DEF_OUT_STRLEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           start,
  input  logic [in_strlen*DWIDTH-1:0]    in_values,
  input  logic                           signal_from_controller,
  output logic [out_strlen*DWIDTH-1:0]   out_string,
  output logic                           string_en,
  output logic                           overflow,
  output logic                           busy
);

  localparam int PW = $clog2(out_strlen + 1);
  localparam int IW = $clog2(in_strlen + 1);

  state_e                          state_q;
  logic [in_strlen*DWIDTH-1:0]     vals_q;
  logic [out_strlen*DWIDTH-1:0]    buf_q;
  logic [out_strlen*DWIDTH-1:0]    str_q;
  logic [PW-1:0]                   ptr_q;
  logic [IW-1:0]                   idx_q;
  logic [1:0]                      dig_q;
  logic                            sep_q;
  logic                            flag_q;
  logic                            en_q;
  logic                            ovf_q;
  logic                            busy_q;

  logic [DWIDTH-1:0] cur_val;
  logic [3:0]        hund, tens, ones, digit;
  logic [1:0]        ndig;
  logic [DWIDTH-1:0] ch;
  logic              last_dig, last_char, at_end;

  assign cur_val = vals_q[(in_strlen-1-int'(idx_q))*DWIDTH +: DWIDTH];

  string_format_bin2bcd u_bin2bcd (
    .bin_i  (cur_val[7:0]),
    .hund_o (hund),
    .tens_o (tens),
    .ones_o (ones),
    .ndig_o (ndig)
  );

  // dig_q counts significant digits already written for the current value, MSB first
  always_comb begin
    digit = ones;
    case (ndig)
      2'd3:    digit = (dig_q == 2'd0) ? hund : ((dig_q == 2'd1) ? tens : ones);
      2'd2:    digit = (dig_q == 2'd0) ? tens : ones;
      default: digit = ones;
    endcase
  end

  assign last_dig  = (dig_q == ndig - 2'd1);
  assign last_char = !sep_q && last_dig && (idx_q == IW'(in_strlen - 1));
  assign at_end    = (ptr_q == PW'(out_strlen - 1));
  assign ch        = sep_q ? DWIDTH'(ASCII_SPACE) : DWIDTH'(ASCII_ZERO + {4'h0, digit});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      vals_q  <= '0;
      buf_q   <= {out_strlen{DWIDTH'(ASCII_SPACE)}};
      str_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      sep_q   <= 1'b0;
      flag_q  <= 1'b0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (!enable) begin
      state_q <= ST_IDLE;
      vals_q  <= '0;
      buf_q   <= {out_strlen{DWIDTH'(ASCII_SPACE)}};
      str_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      sep_q   <= 1'b0;
      flag_q  <= 1'b0;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vals_q  <= in_values;
            buf_q   <= {out_strlen{DWIDTH'(ASCII_SPACE)}};
            ptr_q   <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            sep_q   <= 1'b0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          buf_q[(out_strlen-1-int'(ptr_q))*DWIDTH +: DWIDTH] <= ch;
          ptr_q <= ptr_q + PW'(1);
          // Writing the final byte ends the string; anything still pending is truncated
          if (at_end) begin
            flag_q  <= !last_char;
            state_q <= ST_DONE;
          end else if (last_char) begin
            state_q <= ST_DONE;
          end else if (sep_q) begin
            sep_q <= 1'b0;
            idx_q <= idx_q + IW'(1);
            dig_q <= '0;
          end else if (last_dig) begin
            sep_q <= 1'b1;
          end else begin
            dig_q <= dig_q + 2'd1;
          end
        end
        ST_DONE: begin
          if (!en_q) begin
            str_q <= buf_q;
            en_q  <= 1'b1;
            ovf_q <= flag_q;
          end else if (signal_from_controller) begin
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_string = str_q;
  assign string_en  = en_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_string_format.sv
// Directed bench for string_format: a small (3 values / 8 chars) and a default-sized instance.
module tb_string_format;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable;
  logic         start_s, start_d, ack_s, ack_d;
  logic [23:0]  vals_s;
  logic [79:0]  vals_d;
  logic [63:0]  str_s;
  logic [255:0] str_d;
  logic         en_s, en_d, ovf_s, ovf_d, busy_s, busy_d;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [255:0] str;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t q_s[$];
  exp_t q_d[$];

  string_format #(.DWIDTH(8), .in_strlen(3), .out_strlen(8)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .start(start_s), .in_values(vals_s),
    .signal_from_controller(ack_s), .out_string(str_s), .string_en(en_s),
    .overflow(ovf_s), .busy(busy_s)
  );

  string_format dut_d (
    .clk(clk), .reset(reset), .enable(enable), .start(start_d), .in_values(vals_d),
    .signal_from_controller(ack_d), .out_string(str_d), .string_en(en_d),
    .overflow(ovf_d), .busy(busy_d)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference formatter: full text, then clipped/padded to olen characters
  function automatic exp_t model(input int n, input int olen, input logic [79:0] v);
    exp_t  e;
    string txt;
    int    val;
    txt = "";
    for (int i = 0; i < n; i++) begin
      val = int'(v[(n-1-i)*8 +: 8]);
      txt = {txt, $sformatf("%0d", val)};
      if (i < n - 1) txt = {txt, " "};
    end
    e.str = '0;
    for (int p = 0; p < olen; p++)
      e.str[(olen-1-p)*8 +: 8] = (p < txt.len()) ? txt[p] : 8'h20;
    e.ovf = (txt.len() > olen);
    e.lat = ((txt.len() > olen) ? olen : txt.len()) + 1;
    return e;
  endfunction

  // Consumer-side parser: spaces delimit fields, empty fields read as 0
  function automatic logic [79:0] parse(input logic [255:0] s);
    logic [79:0] r;
    logic [7:0]  c;
    int          idx, acc;
    r = '0; idx = 0; acc = 0;
    for (int p = 0; p < 32; p++) begin
      c = s[(31-p)*8 +: 8];
      if (c == 8'h20) begin
        if (idx < 10) r[(9-idx)*8 +: 8] = 8'(acc);
        idx++;
        acc = 0;
      end else begin
        acc = acc * 10 + int'(c) - 48;
      end
    end
    if (idx < 10) r[(9-idx)*8 +: 8] = 8'(acc);
    return r;
  endfunction

  task automatic run_s(input logic [23:0] v);
    exp_t e;
    int   cyc;
    q_s.push_back(model(3, 8, {56'h0, v}));
    @(negedge clk); vals_s = v; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0; vals_s = ~v;
    cyc = 0;
    while (!en_s && cyc < 100) begin
      @(posedge clk); #1 cyc++;
      if (cyc == 1) chk("s_busy", busy_s, 1'b1);
    end
    e = q_s.pop_front();
    chk("s_latency", cyc, e.lat);
    chk("s_string", str_s, e.str);
    chk("s_overflow", ovf_s, e.ovf);
  endtask

  task automatic run_d(input logic [79:0] v);
    exp_t e;
    int   cyc;
    q_d.push_back(model(10, 32, v));
    @(negedge clk); vals_d = v; start_d = 1'b1;
    @(posedge clk); #1 start_d = 1'b0; vals_d = ~v;
    cyc = 0;
    while (!en_d && cyc < 100) begin
      @(posedge clk); #1 cyc++;
    end
    e = q_d.pop_front();
    chk("d_latency", cyc, e.lat);
    chk("d_string", str_d, e.str);
    chk("d_overflow", ovf_d, e.ovf);
  endtask

  task automatic ack_small();
    logic [63:0] snap;
    snap = str_s;
    @(negedge clk); ack_s = 1'b1;
    @(posedge clk); #1 ack_s = 1'b0;
    chk("s_ack_en", en_s, 1'b0);
    chk("s_ack_busy", busy_s, 1'b0);
    chk("s_ack_retain", str_s, snap);
  endtask

  task automatic ack_dflt();
    @(negedge clk); ack_d = 1'b1;
    @(posedge clk); #1 ack_d = 1'b0;
    chk("d_ack_en", en_d, 1'b0);
  endtask

  initial begin
    logic [255:0] snap;
    logic [79:0]  rv;
    bit           stable;

    reset = 1'b0; enable = 1'b1;
    start_s = 1'b0; start_d = 1'b0; ack_s = 1'b0; ack_d = 1'b0;
    vals_s = '0; vals_d = '0;
    #12;
    chk("rst_str_s", str_s, '0);
    chk("rst_en_s", en_s, 1'b0);
    chk("rst_busy_d", busy_d, 1'b0);
    chk("rst_ovf_d", ovf_d, 1'b0);
    @(negedge clk); reset = 1'b1;

    run_s({8'd12, 8'd0, 8'd255});
    ack_small();

    run_d('0);
    ack_dflt();

    run_d({10{8'd255}});
    snap = str_d; stable = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (!en_d || str_d !== snap) stable = 1'b0;
    end
    chk("d_hold", stable, 1'b1);
    // ack and start together in DONE: only the ack is taken
    @(negedge clk); ack_d = 1'b1; start_d = 1'b1;
    @(posedge clk); #1 ack_d = 1'b0; start_d = 1'b0;
    chk("d_ack_en", en_d, 1'b0);
    @(posedge clk); #1;
    chk("d_start_ignored", busy_d, 1'b0);

    run_s({8'd1, 8'd2, 8'd3});
    ack_small();

    // asynchronous reset in the middle of EMIT
    @(negedge clk); vals_s = {8'd50, 8'd60, 8'd70}; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_str", str_s, '0);
    chk("arst_busy", busy_s, 1'b0);
    @(negedge clk); reset = 1'b1;
    run_s({8'd9, 8'd10, 8'd100});
    ack_small();

    // round trip through a consumer-side parse
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 10; i++) rv[i*8 +: 8] = 8'($urandom_range(99));
      run_d(rv);
      chk("roundtrip", parse(str_d), rv);
      if (t < 3) ack_dflt();
    end

    // synchronous enable drop clears a held result
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    chk("en_clr_en", en_d, 1'b0);
    chk("en_clr_str", str_d, '0);
    chk("en_clr_busy", busy_d, 1'b0);
    @(negedge clk); enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
